flags_stack_register: RTL and testbench

//   Parametrised processor status-flag register with a save/restore stack.

---
 rtl/flags_stack_register.sv | 107 ++++++++++
 tb/tb_flags_stack_register.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/flags_stack_register.sv
`default_nettype none
// ============================================================================
// Module      : flags_stack_register
// Description : Status-flag register with per-bit write enables and a
//               save/restore stack. Define FLAGS_FWD_EN to forward the
//               next-state flags combinationally to o_flags_out.
// Revision    : 1.0 - initial release
// ============================================================================
module flags_stack_register #(
    parameter  int NUM_FLAGS   = 2,
    parameter  int STACK_DEPTH = 4,
    localparam int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FLAGS-1:0] i_flags_in,
    input  logic [NUM_FLAGS-1:0] i_flag_wr_mask,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic                 i_err_clear,
    output logic [NUM_FLAGS-1:0] o_flags_out,
    output logic [CNT_W-1:0]     o_depth,
    output logic                 o_stack_full,
    output logic                 o_stack_empty,
    output logic                 o_overflow_err,
    output logic                 o_underflow_err
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [NUM_FLAGS-1:0] r_flags;
    logic [CNT_W-1:0]     r_depth;
    logic                 r_ovf;
    logic                 r_unf;
    logic [NUM_FLAGS-1:0] r_stack [2**IDX_W];

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic                 w_ovf_set;
    logic                 w_unf_set;
    logic [IDX_W-1:0]     w_push_idx;
    logic [IDX_W-1:0]     w_top_idx;
    logic [NUM_FLAGS-1:0] w_flags_nxt;

    assign w_full     = (r_depth == CNT_W'(STACK_DEPTH));
    assign w_empty    = (r_depth == '0);
    assign w_push_ok  = i_push & ~i_pop & ~w_full;
    assign w_pop_ok   = i_pop & ~i_push & ~w_empty;
    assign w_ovf_set  = i_push & ~i_pop & w_full;
    assign w_unf_set  = i_pop & ~i_push & w_empty;
    assign w_push_idx = IDX_W'(r_depth);
    assign w_top_idx  = IDX_W'(r_depth - 1'b1);

    // A restore from the stack overrides any masked ALU write in the same cycle
    assign w_flags_nxt = w_pop_ok ? r_stack[w_top_idx]
                                  : ((r_flags & ~i_flag_wr_mask) | (i_flags_in & i_flag_wr_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            if (w_push_ok) begin
                r_depth <= r_depth + 1'b1;
            end else if (w_pop_ok) begin
                r_depth <= r_depth - 1'b1;
            end
            // Set takes priority over clear so a concurrent error is never lost
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (i_err_clear) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (i_err_clear) begin
                r_unf <= 1'b0;
            end
        end
    end

    // Frame storage carries no reset; depth alone defines which entries are valid
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_stack[w_push_idx] <= r_flags;
        end
    end

`ifdef FLAGS_FWD_EN
    assign o_flags_out = w_flags_nxt;
`else
    assign o_flags_out = r_flags;
`endif

    assign o_depth         = r_depth;
    assign o_stack_full    = w_full;
    assign o_stack_empty   = w_empty;
    assign o_overflow_err  = r_ovf;
    assign o_underflow_err = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_flags_stack_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_flags_stack_register
// Description : Directed, table-driven self-checking bench for
//               flags_stack_register (NUM_FLAGS=2, STACK_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flags_stack_register;

    logic       clk;
    logic       rst;
    logic [1:0] flags_in;
    logic [1:0] mask;
    logic       push;
    logic       pop;
    logic       err_clear;
    logic [1:0] flags_out;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;

    int n_pass  = 0;
    int n_total = 0;

    flags_stack_register #(
        .NUM_FLAGS   (2),
        .STACK_DEPTH (4)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .i_flags_in      (flags_in),
        .i_flag_wr_mask  (mask),
        .i_push          (push),
        .i_pop           (pop),
        .i_err_clear     (err_clear),
        .o_flags_out     (flags_out),
        .o_depth         (depth),
        .o_stack_full    (full),
        .o_stack_empty   (empty),
        .o_overflow_err  (ovf),
        .o_underflow_err (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [1:0] fi;
        logic [1:0] m;
        logic [1:0] ef;
        logic [2:0] ed;
        logic       eovf;
        logic       eunf;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] ef, input logic [2:0] ed,
                             input logic eovf, input logic eunf);
        chk({tag, ".flags"}, 32'(flags_out), 32'(ef));
        chk({tag, ".depth"}, 32'(depth), 32'(ed));
        chk({tag, ".full"},  32'(full),  32'(ed == 3'd4));
        chk({tag, ".empty"}, 32'(empty), 32'(ed == 3'd0));
        chk({tag, ".ovf"},   32'(ovf),   32'(eovf));
        chk({tag, ".unf"},   32'(unf),   32'(eunf));
    endtask

    task automatic step(input logic p_push, input logic p_pop, input logic p_clr,
                        input logic [1:0] p_fi, input logic [1:0] p_m);
        @(negedge clk);
        push      = p_push;
        pop       = p_pop;
        err_clear = p_clr;
        flags_in  = p_fi;
        mask      = p_m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              push pop clr  fi     m      ef     ed    ovf   unf
        vecs[0]  = '{1'b0,1'b0,1'b0,2'b11,2'b01, 2'b01,3'd0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,2'b10,2'b00, 2'b01,3'd0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b0,2'b10,2'b00, 2'b01,3'd0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,2'b10,2'b00, 2'b01,3'd0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,2'b10,2'b11, 2'b10,3'd1,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,2'b00,2'b00, 2'b01,3'd0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,2'b00,2'b11, 2'b00,3'd0,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,2'b01,2'b11, 2'b01,3'd1,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b0,2'b10,2'b11, 2'b10,3'd2,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b0,2'b11,2'b11, 2'b11,3'd3,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,2'b01,2'b11, 2'b01,3'd4,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,2'b00,2'b00, 2'b01,3'd4,1'b1,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b0,2'b00,2'b00, 2'b11,3'd3,1'b1,1'b0};
        vecs[13] = '{1'b0,1'b1,1'b0,2'b00,2'b00, 2'b10,3'd2,1'b1,1'b0};
        vecs[14] = '{1'b0,1'b1,1'b0,2'b00,2'b00, 2'b01,3'd1,1'b1,1'b0};
        vecs[15] = '{1'b0,1'b1,1'b0,2'b00,2'b00, 2'b00,3'd0,1'b1,1'b0};
        vecs[16] = '{1'b0,1'b1,1'b0,2'b11,2'b00, 2'b00,3'd0,1'b1,1'b1};
        vecs[17] = '{1'b0,1'b1,1'b1,2'b00,2'b00, 2'b00,3'd0,1'b0,1'b1};
        vecs[18] = '{1'b0,1'b0,1'b1,2'b00,2'b00, 2'b00,3'd0,1'b0,1'b0};
        vecs[19] = '{1'b1,1'b0,1'b0,2'b01,2'b11, 2'b01,3'd1,1'b0,1'b0};
        vecs[20] = '{1'b1,1'b0,1'b0,2'b10,2'b11, 2'b10,3'd2,1'b0,1'b0};
        vecs[21] = '{1'b1,1'b1,1'b0,2'b11,2'b11, 2'b11,3'd2,1'b0,1'b0};
        vecs[22] = '{1'b0,1'b1,1'b0,2'b11,2'b11, 2'b01,3'd1,1'b0,1'b0};
        vecs[23] = '{1'b0,1'b1,1'b0,2'b00,2'b00, 2'b00,3'd0,1'b0,1'b0};

        rst = 1'b1; push = 1'b0; pop = 1'b0; err_clear = 1'b0;
        flags_in = 2'b00; mask = 2'b00;
        #3;
        check_all("reset", 2'b00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].fi, vecs[i].m);
            check_all($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ed, vecs[i].eovf, vecs[i].eunf);
        end

        // Asynchronous reset in the middle of a cycle with stacked frames and a sticky error
        step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        step(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        check_all("pre_rst", 2'b11, 3'd1, 1'b0, 1'b1);
        @(negedge clk);
        push = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all("mid_rst", 2'b00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        check_all("post_rst_pop", 2'b00, 3'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
